// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/funct3 constants and ALU operation select for alu
package alu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU funct3 group (R-type and I-type share it)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3 group
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    // Map the shared funct3 group to an operation. alt is funct7[5];
    // allow_sub is cleared for I-type so that 000 is always ADDI.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt,
                                           input logic allow_sub);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_branch_cmp.sv
// rtl/alu_branch_cmp.sv - combinational branch condition evaluation on rs1/rs2
module alu_branch_cmp
    import alu_pkg::*;
(
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    input  logic [2:0]  funct3,
    output logic        taken
);

    // Evaluate the branch condition; reserved encodings 010/011 never take
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (reg1 == reg2);
            F3_BNE:  taken = (reg1 != reg2);
            F3_BLT:  taken = ($signed(reg1) <  $signed(reg2));
            F3_BGE:  taken = ($signed(reg1) >= $signed(reg2));
            F3_BLTU: taken = (reg1 <  reg2);
            F3_BGEU: taken = (reg1 >= reg2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered RV32I execute unit: ALU result, load/store address, branch flag
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ALU_source,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    input  logic [31:0] immediate,
    output logic [31:0] read_address,
    output logic [31:0] write_address,
    output logic [31:0] result,
    output logic        branch
);

    alu_op_e     op;
    logic        use_imm;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic [31:0] operand_b;
    logic [4:0]  shamt;
    logic [31:0] alu_out;
    logic [31:0] mem_addr;
    logic        taken;

    // Only funct7[5] carries meaning for the supported instructions
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Decode opcode into an operation, operand-B source and output enables
    always_comb begin
        op        = ALU_NONE;
        use_imm   = ALU_source;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OP_R: begin
                use_imm = 1'b0;
                op      = alu_decode(funct3, funct7[5], 1'b1);
            end
            OP_I: begin
                use_imm = 1'b1;
                op      = alu_decode(funct3, funct7[5], 1'b0);
            end
            OP_LOAD:   is_load   = 1'b1;
            OP_STORE:  is_store  = 1'b1;
            OP_BRANCH: is_branch = 1'b1;
            OP_LUI: begin
                use_imm = 1'b1;
                op      = ALU_PASS_B;
            end
            default: op = ALU_NONE;
        endcase
    end

    assign operand_b = use_imm ? immediate : reg2;
    assign shamt     = operand_b[4:0];
    assign mem_addr  = reg1 + immediate;

    // ALU datapath; every operation wraps modulo 2^32
    always_comb begin
        alu_out = 32'd0;
        case (op)
            ALU_ADD:    alu_out = reg1 + operand_b;
            ALU_SUB:    alu_out = reg1 - operand_b;
            ALU_SLL:    alu_out = reg1 << shamt;
            ALU_SLT:    alu_out = {31'd0, $signed(reg1) < $signed(operand_b)};
            ALU_SLTU:   alu_out = {31'd0, reg1 < operand_b};
            ALU_XOR:    alu_out = reg1 ^ operand_b;
            ALU_SRL:    alu_out = reg1 >> shamt;
            ALU_SRA:    alu_out = $unsigned($signed(reg1) >>> shamt);
            ALU_OR:     alu_out = reg1 | operand_b;
            ALU_AND:    alu_out = reg1 & operand_b;
            ALU_PASS_B: alu_out = operand_b;
            default:    alu_out = 32'd0;
        endcase
    end

    alu_branch_cmp u_branch_cmp (
        .reg1   (reg1),
        .reg2   (reg2),
        .funct3 (funct3),
        .taken  (taken)
    );

    // Single output register stage; unused outputs are cleared, never held
    always_ff @(posedge clk) begin
        if (rst) begin
            result        <= 32'd0;
            read_address  <= 32'd0;
            write_address <= 32'd0;
            branch        <= 1'b0;
        end else begin
            result        <= alu_out;
            read_address  <= is_load  ? mem_addr : 32'd0;
            write_address <= is_store ? mem_addr : 32'd0;
            branch        <= is_branch & taken;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu
module tb_alu;

    logic        clk;
    logic        rst;
    logic        ALU_source;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] immediate;
    logic [31:0] read_address;
    logic [31:0] write_address;
    logic [31:0] result;
    logic        branch;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] ALT = 7'b0100000;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        src;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [96:0] exp;
    } vec_t;

    alu dut (
        .clk           (clk),
        .rst           (rst),
        .ALU_source    (ALU_source),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .reg1          (reg1),
        .reg2          (reg2),
        .immediate     (immediate),
        .read_address  (read_address),
        .write_address (write_address),
        .result        (result),
        .branch        (branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic src,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [31:0] res,
                                input logic [31:0] rd, input logic [31:0] wr,
                                input logic br);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.src = src;
        v.a = a; v.b = b; v.imm = imm;
        v.exp = {res, rd, wr, br};
        return v;
    endfunction

    // Drive one operation, clock it in, and settle past the edge
    task automatic apply(input vec_t v);
        opcode = v.op; funct3 = v.f3; funct7 = v.f7; ALU_source = v.src;
        reg1 = v.a; reg2 = v.b; immediate = v.imm;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v;
        logic [96:0] got;
        v = mk(R, 3'b000, 7'd0, 1'b0, 32'd5, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply(v);
            got = {result, read_address, write_address, branch};
            checks++;
            if (got !== 97'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got, 97'd0);
            end
        end
        rst = 1'b0;
        apply(v);
        checks++;
        if (result !== 32'd8) begin
            errors++;
            $display("FAIL reset_release result got=%h exp=%h", result, 32'd8);
        end
    endtask

    task automatic test_r_type();
        vec_t q[$];
        logic [96:0] got;
        q.push_back(mk(R, 3'b000, 7'd0, 1'b0, 32'd1, 32'd0, 32'd0, 32'd1, 0, 0, 0));
        q.push_back(mk(R, 3'b000, ALT, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 0, 0, 0));
        q.push_back(mk(R, 3'b000, ALT, 1'b0, 32'd0, 32'd1, 32'd0, 32'hFFFFFFFF, 0, 0, 0));
        q.push_back(mk(R, 3'b010, 7'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 0, 0, 0));
        q.push_back(mk(R, 3'b011, 7'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 0, 0, 0));
        // ALU_source high must not redirect an R-type to the immediate
        q.push_back(mk(R, 3'b000, 7'd0, 1'b1, 32'd10, 32'd5, 32'd100, 32'd15, 0, 0, 0));
        q.push_back(mk(R, 3'b100, 7'd0, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0, 32'h00000FF0, 0, 0, 0));
        q.push_back(mk(R, 3'b110, 7'd0, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0, 32'h0000FFF0, 0, 0, 0));
        q.push_back(mk(R, 3'b111, 7'd0, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0, 32'h0000F000, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            got = {result, read_address, write_address, branch};
            checks++;
            if (got !== q[i].exp) begin
                errors++;
                $display("FAIL r_type[%0d] got=%h exp=%h", i, got, q[i].exp);
            end
        end
    endtask

    task automatic test_i_type();
        vec_t q[$];
        logic [96:0] got;
        q.push_back(mk(I, 3'b000, ALT, 1'b1, 32'd1, 32'd100, 32'd1, 32'd2, 0, 0, 0));
        q.push_back(mk(I, 3'b100, 7'd0, 1'b1, 32'd1, 32'd100, 32'd1, 32'd0, 0, 0, 0));
        q.push_back(mk(I, 3'b110, 7'd0, 1'b1, 32'd1, 32'd100, 32'd1, 32'd1, 0, 0, 0));
        q.push_back(mk(I, 3'b111, 7'd0, 1'b1, 32'd1, 32'd100, 32'd1, 32'd1, 0, 0, 0));
        // I-type uses the immediate even with ALU_source low
        q.push_back(mk(I, 3'b000, 7'd0, 1'b0, 32'd1, 32'd100, 32'd1, 32'd2, 0, 0, 0));
        q.push_back(mk(I, 3'b101, ALT, 1'b1, 32'h80000000, 32'd0, 32'h00000404, 32'hF8000000, 0, 0, 0));
        q.push_back(mk(I, 3'b101, 7'd0, 1'b1, 32'h80000000, 32'd0, 32'h00000004, 32'h08000000, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            got = {result, read_address, write_address, branch};
            checks++;
            if (got !== q[i].exp) begin
                errors++;
                $display("FAIL i_type[%0d] got=%h exp=%h", i, got, q[i].exp);
            end
        end
    endtask

    task automatic test_shifts();
        vec_t q[$];
        logic [96:0] got;
        q.push_back(mk(R, 3'b001, 7'd0, 1'b0, 32'd1, 32'd32, 32'd0, 32'd1, 0, 0, 0));
        q.push_back(mk(R, 3'b001, 7'd0, 1'b0, 32'd1, 32'd16, 32'd0, 32'h00010000, 0, 0, 0));
        q.push_back(mk(R, 3'b001, 7'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd2, 0, 0, 0));
        q.push_back(mk(R, 3'b101, ALT, 1'b0, 32'h80000000, 32'd4, 32'd0, 32'hF8000000, 0, 0, 0));
        q.push_back(mk(R, 3'b101, 7'd0, 1'b0, 32'h80000000, 32'd4, 32'd0, 32'h08000000, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            got = {result, read_address, write_address, branch};
            checks++;
            if (got !== q[i].exp) begin
                errors++;
                $display("FAIL shifts[%0d] got=%h exp=%h", i, got, q[i].exp);
            end
        end
    endtask

    task automatic test_branches();
        vec_t q[$];
        logic [96:0] got;
        q.push_back(mk(BR, 3'b000, 7'd0, 1'b0, 32'd7, 32'd7, 32'd0, 0, 0, 0, 1'b1));
        q.push_back(mk(BR, 3'b001, 7'd0, 1'b0, 32'd7, 32'd7, 32'd0, 0, 0, 0, 1'b0));
        q.push_back(mk(BR, 3'b100, 7'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 0, 1'b1));
        q.push_back(mk(BR, 3'b110, 7'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 0, 1'b0));
        q.push_back(mk(BR, 3'b111, 7'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 0, 1'b1));
        q.push_back(mk(BR, 3'b101, 7'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 0, 1'b0));
        q.push_back(mk(BR, 3'b010, 7'd0, 1'b0, 32'd7, 32'd7, 32'd0, 0, 0, 0, 1'b0));
        q.push_back(mk(BR, 3'b011, 7'd0, 1'b0, 32'd7, 32'd7, 32'd0, 0, 0, 0, 1'b0));
        // Branch compares reg2, never the immediate
        q.push_back(mk(BR, 3'b000, 7'd0, 1'b1, 32'd7, 32'd7, 32'd9, 0, 0, 0, 1'b1));
        foreach (q[i]) begin
            apply(q[i]);
            got = {result, read_address, write_address, branch};
            checks++;
            if (got !== q[i].exp) begin
                errors++;
                $display("FAIL branch[%0d] got=%h exp=%h", i, got, q[i].exp);
            end
        end
    endtask

    task automatic test_mem_default();
        vec_t q[$];
        logic [96:0] got;
        q.push_back(mk(LD, 3'b010, 7'd0, 1'b1, 32'h100, 32'd5, 32'hFFFFFFFC, 0, 32'hFC, 0, 0));
        q.push_back(mk(ST, 3'b010, 7'd0, 1'b1, 32'h100, 32'd5, 32'hFFFFFFFC, 0, 0, 32'hFC, 0));
        q.push_back(mk(LUI, 3'b000, 7'd0, 1'b1, 32'd3, 32'd5, 32'h12345000, 32'h12345000, 0, 0, 0));
        q.push_back(mk(7'b1111111, 3'b000, 7'd0, 1'b1, 32'd7, 32'd7, 32'd5, 0, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            got = {result, read_address, write_address, branch};
            checks++;
            if (got !== q[i].exp) begin
                errors++;
                $display("FAIL mem_default[%0d] got=%h exp=%h", i, got, q[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t q[$];
        logic [96:0] got;
        q.push_back(mk(BR, 3'b000, 7'd0, 1'b0, 32'd4, 32'd4, 32'd0, 0, 0, 0, 1'b1));
        q.push_back(mk(LD, 3'b000, 7'd0, 1'b1, 32'h20, 32'd0, 32'h10, 0, 32'h30, 0, 0));
        q.push_back(mk(ST, 3'b000, 7'd0, 1'b1, 32'h20, 32'd0, 32'h8, 0, 0, 32'h28, 0));
        q.push_back(mk(R, 3'b000, 7'd0, 1'b0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd1, 0, 0, 0));
        q.push_back(mk(R, 3'b000, 7'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            got = {result, read_address, write_address, branch};
            checks++;
            if (got !== q[i].exp) begin
                errors++;
                $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, q[i].exp);
            end
        end
        // Reset asserted mid-stream overrides a live ADD at the same edge
        rst = 1'b1;
        apply(mk(R, 3'b000, 7'd0, 1'b0, 32'd9, 32'd9, 32'd0, 0, 0, 0, 0));
        got = {result, read_address, write_address, branch};
        checks++;
        if (got !== 97'd0) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h", got, 97'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ALU_source = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        reg1 = 32'd0; reg2 = 32'd0; immediate = 32'd0;
        test_reset();
        test_r_type();
        test_i_type();
        test_shifts();
        test_branches();
        test_mem_default();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
